reg_write_arbiter: RTL and testbench

- Shares one 8-bit enable-gated storage register among NUM_REQ requesters using round-robin arbitration.
- Drives the register's enable and 8-bit data inputs, and returns a one-hot grant and a one-cycle ack to the winning requester.
- Sits between the requester logic and the shared register; it is the only source of that register's write enable.
- Also keeps a wrapping count of committed writes.

---
 rtl/reg_write_arbiter.sv | 124 ++++++++++++
 tb/tb_reg_write_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin write arbiter for a shared enable-gated 8-bit register
module reg_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      reg_en,
  output logic [DATA_W-1:0]         reg_d,
  output logic                      busy,
  output logic [1:0]                last_id,
  output logic [7:0]                wr_count
);

  localparam int ID_W = 2;

  typedef enum logic [1:0] {IDLE, GRANT, WRITE} state_t;

  state_t            state;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   win;
  logic [DATA_W-1:0] hold;

  logic [NUM_REQ-1:0] cand;
  logic [DATA_W-1:0]  wd [NUM_REQ];
  logic               pick_vld;
  logic [ID_W-1:0]    pick_id;
  logic [ID_W-1:0]    idx;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      wd[i] = wdata[i*DATA_W +: DATA_W];
    end
  end

  // During WRITE the pointer already sits at win+1, so the current winner is simply masked out.
  always_comb begin
    cand = req;
    if (state == WRITE) begin
      cand[win] = 1'b0;
    end
  end

  // Scan from the farthest offset down so the lowest offset from ptr wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = ptr;
    idx      = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ptr + ID_W'(k);
      if (cand[idx]) begin
        pick_vld = 1'b1;
        pick_id  = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      gnt      <= '0;
      ack      <= '0;
      reg_en   <= 1'b0;
      reg_d    <= '0;
      busy     <= 1'b0;
      last_id  <= '0;
      wr_count <= '0;
      ptr      <= '0;
      win      <= '0;
      hold     <= '0;
    end else begin
      ack    <= '0;
      reg_en <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state <= GRANT;
            win   <= pick_id;
            gnt   <= NUM_REQ'(1) << pick_id;
            hold  <= wd[pick_id];
            busy  <= 1'b1;
          end
        end
        GRANT: begin
          if (req[win]) begin
            state    <= WRITE;
            reg_en   <= 1'b1;
            reg_d    <= hold;
            ack      <= gnt;
            last_id  <= win;
            wr_count <= wr_count + 8'd1;
            ptr      <= win + ID_W'(1);
          end else begin
            state <= IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
          end
        end
        WRITE: begin
          if (pick_vld) begin
            state <= GRANT;
            win   <= pick_id;
            gnt   <= NUM_REQ'(1) << pick_id;
            hold  <= wd[pick_id];
          end else begin
            state <= IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - randomized bench for reg_write_arbiter against a transaction-level model
module tb_reg_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic        reg_en;
  logic [7:0]  reg_d;
  logic        busy;
  logic [1:0]  last_id;
  logic [7:0]  wr_count;

  reg_write_arbiter #(.NUM_REQ(4), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .req(req), .wdata(wdata),
    .gnt(gnt), .ack(ack), .reg_en(reg_en), .reg_d(reg_d),
    .busy(busy), .last_id(last_id), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: who owns the register (-1 none) and whether that owner's write is being issued now.
  int       m_owner;
  bit       m_issuing;
  int       m_ptr;
  int       m_last;
  int       m_cnt;
  logic [7:0] m_hold;
  logic [7:0] m_regd;
  int       tick_no = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (tick %0d)", tag, obs, exp, tick_no);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] mask, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (mask[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_gnt();
    logic [3:0] one = 4'b0001;
    if (m_owner < 0) return 4'b0000;
    return one << m_owner;
  endfunction

  function automatic logic [7:0] slot(input int id);
    logic [31:0] w = wdata;
    return w[id*8 +: 8];
  endfunction

  task automatic model_step();
    int w;
    logic [3:0] mask;
    if (!reset) begin
      m_owner = -1; m_issuing = 0; m_ptr = 0; m_last = 0; m_cnt = 0; m_regd = 8'h00;
    end else if (m_owner < 0) begin
      w = rr_pick(req, m_ptr);
      if (w >= 0) begin m_owner = w; m_hold = slot(w); m_issuing = 0; end
    end else if (!m_issuing) begin
      if (req[m_owner]) begin
        m_issuing = 1; m_regd = m_hold; m_last = m_owner;
        m_cnt = (m_cnt + 1) % 256; m_ptr = (m_owner + 1) % 4;
      end else begin
        m_owner = -1;
      end
    end else begin
      mask = req;
      mask[m_owner] = 1'b0;
      w = rr_pick(mask, m_ptr);
      m_issuing = 0;
      if (w >= 0) begin m_owner = w; m_hold = slot(w); end
      else m_owner = -1;
    end
  endtask

  task automatic compare_all();
    check("gnt", gnt, exp_gnt());
    check("ack", ack, m_issuing ? exp_gnt() : 4'b0000);
    check("reg_en", reg_en, m_issuing);
    check("reg_d", reg_d, m_regd);
    check("busy", busy, m_owner >= 0);
    check("last_id", last_id, m_last);
    check("wr_count", wr_count, m_cnt);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    tick_no++;
    compare_all();
  endtask

  task automatic set_data(input int id, input logic [7:0] d);
    wdata[id*8 +: 8] = d;
  endtask

  task automatic do_reset();
    reset = 1'b0; req = 4'b0000;
    tick(); tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic single_write(input int id, input logic [7:0] d);
    int n = 0;
    set_data(id, d);
    req[id] = 1'b1;
    do begin
      tick();
      n++;
    end while (!(m_issuing && m_owner == id) && n < 10);
    check("single_ack_seen", ack[id], 1'b1);
    req[id] = 1'b0;
    tick();
  endtask

  logic [7:0] got[$];
  int         got_t[$];
  logic [3:0] ack_exp;

  initial begin
    reset = 1'b0; req = 4'b0000; wdata = 32'h0;
    m_owner = -1; m_issuing = 0; m_ptr = 0; m_last = 0; m_cnt = 0; m_regd = 0; m_hold = 0;
    @(negedge clk);
    do_reset();

    // Single write from requester 0.
    set_data(0, 8'hA5); req = 4'b0001;
    tick();
    check("t1_gnt", gnt, 4'b0001);
    tick();
    check("t1_reg_en", reg_en, 1'b1);
    check("t1_reg_d", reg_d, 8'hA5);
    check("t1_ack", ack, 4'b0001);
    check("t1_count", wr_count, 8'd1);
    check("t1_last", last_id, 2'd0);
    req = 4'b0000;
    tick(); tick();

    // Full contention: writes must come out 0..3 on every second cycle.
    do_reset();
    wdata = {8'h44, 8'h33, 8'h22, 8'h11}; req = 4'b1111;
    for (int i = 0; i < 20 && (req != 0 || m_owner >= 0); i++) begin
      if (reg_en) begin got.push_back(reg_d); got_t.push_back(tick_no); end
      ack_exp = m_issuing ? exp_gnt() : 4'b0000;
      req = req & ~ack_exp;
      tick();
    end
    check("t2_nwrites", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      check("t2_order", got[i], 8'h11 * (i + 1));
      if (i > 0) check("t2_spacing", got_t[i] - got_t[i-1], 2);
    end
    check("t2_count", wr_count, 8'd4);
    check("t2_last", last_id, 2'd3);

    // Abort in GRANT keeps the pointer where it was.
    do_reset();
    single_write(1, 8'h10);
    set_data(2, 8'h20); set_data(1, 8'h21);
    req = 4'b0100;
    tick();
    check("t3_gnt", gnt, 4'b0100);
    req = 4'b0000;
    tick();
    check("t3_no_en", reg_en, 1'b0);
    check("t3_no_ack", ack, 4'b0000);
    check("t3_idle", busy, 1'b0);
    req = 4'b0110;
    tick();
    check("t3_regrant", gnt, 4'b0100);
    tick();
    check("t3_data", reg_d, 8'h20);
    req[2] = 1'b0;
    tick(); tick();
    req = 4'b0000;
    tick(); tick();

    // Reset as the write would be issued.
    do_reset();
    set_data(0, 8'h5A); req = 4'b0001;
    tick();
    reset = 1'b0;
    tick();
    check("t4_reg_en", reg_en, 1'b0);
    check("t4_ack", ack, 4'b0000);
    check("t4_gnt", gnt, 4'b0000);
    check("t4_count", wr_count, 8'd0);
    reset = 1'b1; req = 4'b0000;
    tick(); tick();

    // Counter wrap.
    do_reset();
    for (int i = 0; i < 256; i++) single_write(1, 8'($urandom));
    check("t5_wrap", wr_count, 8'd0);
    check("t5_last", last_id, 2'd1);

    // Pointer wrap 3 -> 0.
    single_write(3, 8'h33);
    set_data(0, 8'h0A);
    req = 4'b1001;
    tick();
    check("t6_gnt", gnt, 4'b0001);
    tick();
    req[0] = 1'b0;
    tick(); tick();
    req = 4'b0000;
    tick(); tick();

    // Randomized traffic obeying the requester rules, with occasional aborts and resets.
    for (int c = 0; c < 4000; c++) begin
      ack_exp = m_issuing ? exp_gnt() : 4'b0000;
      for (int i = 0; i < 4; i++) begin
        if (req[i]) begin
          if (ack_exp[i]) req[i] = ($urandom % 4) == 0;
          else if (m_owner == i && !m_issuing && ($urandom % 16) == 0) req[i] = 1'b0;
        end else if (($urandom % 4) == 0) begin
          req[i] = 1'b1;
          set_data(i, 8'($urandom));
        end
      end
      reset = (($urandom % 500) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
